// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns PC and instruction/immediate registers upstream of the decoder.
// Optional breakpoint-to-halt logic is enabled by defining FETCH_BREAKPOINT_EN.
module fetch_sequencer #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_en,
  input  logic             pc_sload,
  input  logic [WIDTH-1:0] new_pc,
  input  logic [WIDTH-1:0] instr_out1,
  input  logic [WIDTH-1:0] instr_out2,
  input  logic             mem_ready,
  input  logic             stall,
`ifdef FETCH_BREAKPOINT_EN
  input  logic             bkpt_en,
  input  logic [WIDTH-1:0] bkpt_addr,
`endif
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] pc,
  output logic             instr_valid,
  output logic             halted
);

  typedef enum logic [1:0] {StBoot, StRun, StWait, StHalt} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] pc_upd;
  logic             load;

  // sload has priority over increment; increment wraps modulo 2^WIDTH.
  assign pc_upd = pc_sload ? new_pc : (cnt_en ? pc_q + WIDTH'(1) : pc_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    n_d     = n_q;
    load    = 1'b0;
    unique case (state_q)
      StBoot: begin
        if (mem_ready) begin
          instr_d = instr_out1;
          n_d     = instr_out2;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!stall) begin
          if (instr_q[15:11] == 5'b11111) begin
            state_d = StHalt;
          end else if (!mem_ready) begin
            state_d = StWait;
          end else begin
            load = 1'b1;
          end
        end
      end
      StWait: begin
        if (mem_ready && !stall) begin
          load = 1'b1;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StBoot;
    endcase

    if (load) begin
      pc_d    = pc_upd;
      instr_d = instr_out1;
      n_d     = instr_out2;
      state_d = StRun;
`ifdef FETCH_BREAKPOINT_EN
      // Only a real PC write can hit the breakpoint; the load itself still completes.
      if (bkpt_en && (pc_sload || cnt_en) && (pc_upd == bkpt_addr)) begin
        state_d = StHalt;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      n_q     <= n_d;
    end
  end

  assign instr       = instr_q;
  assign N           = n_q;
  assign pc          = pc_q;
  assign halted      = (state_q == StHalt);
  assign instr_valid = (state_q == StRun) && !stall;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer; breakpoint steps compile only with
// FETCH_BREAKPOINT_EN defined.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cnt_en = 1'b0;
  logic        pc_sload = 1'b0;
  logic [15:0] new_pc = '0;
  logic [15:0] instr_out1 = '0;
  logic [15:0] instr_out2 = '0;
  logic        mem_ready = 1'b0;
  logic        stall = 1'b0;
`ifdef FETCH_BREAKPOINT_EN
  logic        bkpt_en = 1'b0;
  logic [15:0] bkpt_addr = '0;
`endif
  logic [15:0] instr, n_w, pc;
  logic        instr_valid, halted;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] n;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb[$];

  fetch_sequencer #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_en     (cnt_en),
    .pc_sload   (pc_sload),
    .new_pc     (new_pc),
    .instr_out1 (instr_out1),
    .instr_out2 (instr_out2),
    .mem_ready  (mem_ready),
    .stall      (stall),
`ifdef FETCH_BREAKPOINT_EN
    .bkpt_en    (bkpt_en),
    .bkpt_addr  (bkpt_addr),
`endif
    .instr      (instr),
    .N          (n_w),
    .pc         (pc),
    .instr_valid(instr_valid),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [15:0] p, input logic [15:0] i, input logic [15:0] n,
                      input logic v, input logic h);
    exp_t e;
    e.pc = p; e.instr = i; e.n = n; e.valid = v; e.halted = h;
    sb.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (pc === e.pc) else begin
      failures++; $error("FAIL %s pc: got %h want %h", tag, pc, e.pc);
    end
    checks++;
    assert (instr === e.instr) else begin
      failures++; $error("FAIL %s instr: got %h want %h", tag, instr, e.instr);
    end
    checks++;
    assert (n_w === e.n) else begin
      failures++; $error("FAIL %s N: got %h want %h", tag, n_w, e.n);
    end
    checks++;
    assert (instr_valid === e.valid) else begin
      failures++; $error("FAIL %s instr_valid: got %b want %b", tag, instr_valid, e.valid);
    end
    checks++;
    assert (halted === e.halted) else begin
      failures++; $error("FAIL %s halted: got %b want %b", tag, halted, e.halted);
    end
  endtask

  // Push expectation, advance one rising edge, sample 1 time unit later, compare.
  task automatic step(input string tag, input logic [15:0] p, input logic [15:0] i,
                      input logic [15:0] n, input logic v, input logic h);
    push(p, i, n, v, h);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic now(input string tag, input logic [15:0] p, input logic [15:0] i,
                     input logic [15:0] n, input logic v, input logic h);
    push(p, i, n, v, h);
    #1;
    compare(tag);
  endtask

  initial begin
    #2;
    now("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step("boot_wait", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);

    mem_ready = 1'b1; cnt_en = 1'b1;
    instr_out1 = 16'h0000; instr_out2 = 16'h1234;
    step("boot_run", 16'h0000, 16'h0000, 16'h1234, 1'b1, 1'b0);
    instr_out1 = 16'h1111; instr_out2 = 16'h2222;
    step("cnt1", 16'h0001, 16'h1111, 16'h2222, 1'b1, 1'b0);
    instr_out1 = 16'h0000; instr_out2 = 16'h0000;
    step("cnt2", 16'h0002, 16'h0000, 16'h0000, 1'b1, 1'b0);

    pc_sload = 1'b1; new_pc = 16'h0010;
    step("sload10", 16'h0010, 16'h0000, 16'h0000, 1'b1, 1'b0);
    new_pc = 16'h0042;
    step("sload_wins", 16'h0042, 16'h0000, 16'h0000, 1'b1, 1'b0);
    pc_sload = 1'b0; cnt_en = 1'b0; instr_out1 = 16'h0abc;
    step("pc_hold", 16'h0042, 16'h0abc, 16'h0000, 1'b1, 1'b0);
    pc_sload = 1'b1; new_pc = 16'hffff; instr_out1 = 16'h0000;
    step("sload_ffff", 16'hffff, 16'h0000, 16'h0000, 1'b1, 1'b0);
    pc_sload = 1'b0; cnt_en = 1'b1;
    step("wrap", 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    pc_sload = 1'b1; new_pc = 16'h0005;
    step("sload5", 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0);

    pc_sload = 1'b0; mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) step("wait", 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0);
    mem_ready = 1'b1; instr_out2 = 16'h5555;
    step("wait_exit", 16'h0006, 16'h0000, 16'h5555, 1'b1, 1'b0);

    stall = 1'b1;
    now("stall_comb", 16'h0006, 16'h0000, 16'h5555, 1'b0, 1'b0);
    step("stall_hold", 16'h0006, 16'h0000, 16'h5555, 1'b0, 1'b0);
    stall = 1'b0;
    step("stall_rel", 16'h0007, 16'h0000, 16'h5555, 1'b1, 1'b0);

    mem_ready = 1'b0;
    step("wait2", 16'h0007, 16'h0000, 16'h5555, 1'b0, 1'b0);
    mem_ready = 1'b1; stall = 1'b1;
    step("wait_stall", 16'h0007, 16'h0000, 16'h5555, 1'b0, 1'b0);
    stall = 1'b0;
    step("wait2_exit", 16'h0008, 16'h0000, 16'h5555, 1'b1, 1'b0);

    instr_out1 = 16'hf800;
    step("stp_latch", 16'h0009, 16'hf800, 16'h5555, 1'b1, 1'b0);
    stall = 1'b1;
    step("stp_stalled", 16'h0009, 16'hf800, 16'h5555, 1'b0, 1'b0);
    stall = 1'b0; instr_out1 = 16'h0000;
    step("halt", 16'h0009, 16'hf800, 16'h5555, 1'b0, 1'b1);
    step("halt_frozen", 16'h0009, 16'hf800, 16'h5555, 1'b0, 1'b1);

    reset = 1'b1;
    now("async_reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);

`ifdef FETCH_BREAKPOINT_EN
    bkpt_en = 1'b1; bkpt_addr = 16'h0003;
    @(negedge clk);
    reset = 1'b0;
    instr_out1 = 16'h0000; instr_out2 = 16'h0000;
    step("bk_boot", 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    step("bk_pc1", 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0);
    step("bk_pc2", 16'h0002, 16'h0000, 16'h0000, 1'b1, 1'b0);
    step("bk_hit", 16'h0003, 16'h0000, 16'h0000, 1'b0, 1'b1);
    step("bk_frozen", 16'h0003, 16'h0000, 16'h0000, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1, "timeout");
  end

endmodule
